// File: rtl/bumpy_game_pkg.sv
// Shared types and constants for the Bumpy game-level sequencer.
package bumpy_game_pkg;

  // Top-level game states; the encoding is visible on state_o for the HUD.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPAWN     = 3'd1,
    PLAY      = 3'd2,
    DYING     = 3'd3,
    WIN_LEVEL = 3'd4,
    GAME_OVER = 3'd5,
    VICTORY   = 3'd6
  } state_e;

  // Per-level physics handed to the movement block (all signed).
  typedef struct packed {
    logic signed [31:0] y_accel;
    logic signed [31:0] side_speed_x;
    logic signed [31:0] jump_speed_y_step;
    logic signed [31:0] jump_speed_y_up;
    logic signed [31:0] y_speed_lower_limit;
    logic signed [31:0] y_speed_upper_limit;
  } physics_t;

  localparam int FC_W    = 8;   // frame counter width
  localparam int TIME_W  = 11;  // level timer width
  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 2;

  // Each level is a little faster sideways and falls a little harder.
  localparam physics_t PHYS_TABLE [4] = '{
    '{32'sd3, 32'sd76,  32'sd100, 32'sd200, 32'sd170, 32'sd250},
    '{32'sd4, 32'sd84,  32'sd100, 32'sd200, 32'sd170, 32'sd250},
    '{32'sd5, 32'sd92,  32'sd100, 32'sd200, 32'sd170, 32'sd250},
    '{32'sd6, 32'sd100, 32'sd100, 32'sd200, 32'sd170, 32'sd250}
  };

endpackage

// File: rtl/bumpy_edge_detect.sv
// Falling-edge detector for an active-low level-sensitive key.
// The previous-sample register resets to 1 so a key already held
// during reset does not produce a spurious edge.
module bumpy_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_n_i,
  output logic fall_o
);

  logic prev_q;

  // Remember last cycle's key level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sig_n_i;
    end
  end

  assign fall_o = prev_q & ~sig_n_i;

endmodule

// File: rtl/bumpy_game_ctrl.sv
// Game-level sequencer for the Bumpy player: owns lives, level, the
// per-level countdown and the physics table, gates the movement keys and
// issues the one-cycle EndGame respawn pulse.
module bumpy_game_ctrl
  import bumpy_game_pkg::*;
#(
  parameter int START_LIVES       = 3,
  parameter int NUM_LEVELS        = 4,
  parameter int SPAWN_FRAMES      = 30,
  parameter int DEATH_FRAMES      = 45,
  parameter int WIN_FRAMES        = 60,
  parameter int LEVEL_TIME_FRAMES = 1800
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                startOfFrame,
  input  logic                startKeyN,
  input  logic                rightN_in,
  input  logic                leftN_in,
  input  logic                jumpN_in,
  input  logic                hitHazard,
  input  logic                hitGoal,
  output logic                rightN,
  output logic                leftN,
  output logic                jumpN,
  output logic                EndGame,
  output logic signed [31:0]  Y_ACCEL,
  output logic signed [31:0]  sideSpeedX,
  output logic signed [31:0]  jumpSpeedYstep,
  output logic signed [31:0]  jumpSpeedYUp,
  output logic signed [31:0]  Y_SPEED_LOWER_LIMIT,
  output logic signed [31:0]  Y_SPEED_UPPER_LIMIT,
  output logic [LIVES_W-1:0]  lives,
  output logic [LEVEL_W-1:0]  level,
  output logic [TIME_W-1:0]   timeLeft,
  output logic [2:0]          state_o,
  output logic                gameOver,
  output logic                victory
);

  localparam logic [FC_W-1:0]    SPAWN_FC    = FC_W'(SPAWN_FRAMES);
  localparam logic [FC_W-1:0]    DEATH_FC    = FC_W'(DEATH_FRAMES);
  localparam logic [FC_W-1:0]    WIN_FC      = FC_W'(WIN_FRAMES);
  localparam logic [TIME_W-1:0]  TIME_RELOAD = TIME_W'(LEVEL_TIME_FRAMES);
  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(START_LIVES);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);

  state_e              state_q, state_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [TIME_W-1:0]   time_q,  time_d;
  logic [FC_W-1:0]     fc_q,    fc_d;
  logic                eg_q,    eg_d;
  logic                pend_q,  pend_d;   // start edge seen on a frame pulse, spawn still owed
  logic                start_edge;
  physics_t            phys;

  bumpy_edge_detect u_start_edge (
    .clk     (clk),
    .reset   (reset),
    .sig_n_i (startKeyN),
    .fall_o  (start_edge)
  );

  // State, counters and the registered EndGame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lives_q <= LIVES_INIT;
      level_q <= '0;
      time_q  <= TIME_RELOAD;
      fc_q    <= '0;
      eg_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      time_q  <= time_d;
      fc_q    <= fc_d;
      eg_q    <= eg_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic. Any move into SPAWN is held off while startOfFrame is
  // high so the respawn pulse never lands on the movement block's frame
  // update; because fc may then step past its target, the DYING/WIN_LEVEL
  // exits compare with >=.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    time_d  = time_q;
    eg_d    = 1'b0;
    pend_d  = pend_q;

    unique case (state_q)
      IDLE: begin
        if (start_edge || pend_q) begin
          if (startOfFrame) begin
            pend_d = 1'b1;
          end else begin
            state_d = SPAWN;
            lives_d = LIVES_INIT;
            level_d = '0;
            time_d  = TIME_RELOAD;
            eg_d    = 1'b1;
            pend_d  = 1'b0;
          end
        end
      end

      SPAWN: begin
        if (fc_q == SPAWN_FC) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (hitHazard) begin
          state_d = DYING;
        end else if (hitGoal) begin
          state_d = WIN_LEVEL;
        end else if (startOfFrame) begin
          if (time_q == TIME_W'(1)) begin
            time_d  = '0;
            state_d = DYING;
          end else if (time_q != '0) begin
            time_d = time_q - TIME_W'(1);
          end
        end
      end

      DYING: begin
        if (fc_q >= DEATH_FC) begin
          if (lives_q <= LIVES_W'(1)) begin
            state_d = GAME_OVER;
            lives_d = '0;
          end else if (!startOfFrame) begin
            state_d = SPAWN;
            lives_d = lives_q - LIVES_W'(1);
            time_d  = TIME_RELOAD;
            eg_d    = 1'b1;
          end
        end
      end

      WIN_LEVEL: begin
        if (fc_q >= WIN_FC) begin
          if (level_q == LAST_LEVEL) begin
            state_d = VICTORY;
          end else if (!startOfFrame) begin
            state_d = SPAWN;
            level_d = level_q + LEVEL_W'(1);
            time_d  = TIME_RELOAD;
            eg_d    = 1'b1;
          end
        end
      end

      GAME_OVER, VICTORY: begin
        if (start_edge) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame counter restarts on every state change and counts frame pulses.
  always_comb begin
    fc_d = fc_q;
    if (state_d != state_q) begin
      fc_d = '0;
    end else if (startOfFrame) begin
      fc_d = fc_q + FC_W'(1);
    end
  end

  // Movement keys reach the player only while in PLAY.
  always_comb begin
    rightN = 1'b1;
    leftN  = 1'b1;
    jumpN  = 1'b1;
    if (state_q == PLAY) begin
      rightN = rightN_in;
      leftN  = leftN_in;
      jumpN  = jumpN_in;
    end
  end

  assign phys                = PHYS_TABLE[level_q];
  assign Y_ACCEL             = phys.y_accel;
  assign sideSpeedX          = phys.side_speed_x;
  assign jumpSpeedYstep      = phys.jump_speed_y_step;
  assign jumpSpeedYUp        = phys.jump_speed_y_up;
  assign Y_SPEED_LOWER_LIMIT = phys.y_speed_lower_limit;
  assign Y_SPEED_UPPER_LIMIT = phys.y_speed_upper_limit;

  assign EndGame  = eg_q;
  assign lives    = lives_q;
  assign level    = level_q;
  assign timeLeft = time_q;
  assign state_o  = state_q;
  assign gameOver = (state_q == GAME_OVER);
  assign victory  = (state_q == VICTORY);

endmodule

// File: tb/tb_bumpy_game_ctrl.sv
// Self-checking bench: two controllers share stimulus, one with default
// timing and one with a 5-frame level timer, each tracked by its own
// behavioural model; a directed scenario table and hand sequences on top.
module tb_bumpy_game_ctrl;
  import bumpy_game_pkg::*;

  logic clk = 1'b0;
  logic reset, startOfFrame, startKeyN;
  logic rightN_in, leftN_in, jumpN_in, hitHazard, hitGoal;

  logic               rn_o [2];
  logic               ln_o [2];
  logic               jn_o [2];
  logic               eg_o [2];
  logic               go_o [2];
  logic               vic_o [2];
  logic signed [31:0] yacc_o [2];
  logic signed [31:0] side_o [2];
  logic signed [31:0] jstep_o [2];
  logic signed [31:0] jup_o [2];
  logic signed [31:0] ylo_o [2];
  logic signed [31:0] yhi_o [2];
  logic [2:0]         lives_o [2];
  logic [1:0]         level_o [2];
  logic [10:0]        time_o [2];
  logic [2:0]         st_o [2];

  int n_vec = 0;
  int n_bad = 0;
  int eg_cnt = 0;

  always #5 clk = ~clk;

  bumpy_game_ctrl dut0 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .startKeyN(startKeyN),
    .rightN_in(rightN_in), .leftN_in(leftN_in), .jumpN_in(jumpN_in),
    .hitHazard(hitHazard), .hitGoal(hitGoal),
    .rightN(rn_o[0]), .leftN(ln_o[0]), .jumpN(jn_o[0]), .EndGame(eg_o[0]),
    .Y_ACCEL(yacc_o[0]), .sideSpeedX(side_o[0]), .jumpSpeedYstep(jstep_o[0]),
    .jumpSpeedYUp(jup_o[0]), .Y_SPEED_LOWER_LIMIT(ylo_o[0]), .Y_SPEED_UPPER_LIMIT(yhi_o[0]),
    .lives(lives_o[0]), .level(level_o[0]), .timeLeft(time_o[0]), .state_o(st_o[0]),
    .gameOver(go_o[0]), .victory(vic_o[0])
  );

  bumpy_game_ctrl #(.LEVEL_TIME_FRAMES(5)) dut1 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .startKeyN(startKeyN),
    .rightN_in(rightN_in), .leftN_in(leftN_in), .jumpN_in(jumpN_in),
    .hitHazard(hitHazard), .hitGoal(hitGoal),
    .rightN(rn_o[1]), .leftN(ln_o[1]), .jumpN(jn_o[1]), .EndGame(eg_o[1]),
    .Y_ACCEL(yacc_o[1]), .sideSpeedX(side_o[1]), .jumpSpeedYstep(jstep_o[1]),
    .jumpSpeedYUp(jup_o[1]), .Y_SPEED_LOWER_LIMIT(ylo_o[1]), .Y_SPEED_UPPER_LIMIT(yhi_o[1]),
    .lives(lives_o[1]), .level(level_o[1]), .timeLeft(time_o[1]), .state_o(st_o[1]),
    .gameOver(go_o[1]), .victory(vic_o[1])
  );

  // ---------------- behavioural model ----------------
  state_e m_state [2];
  int     m_lives [2];
  int     m_level [2];
  int     m_time  [2];
  int     m_fc    [2];
  int     m_eg    [2];
  int     m_pend  [2];
  int     m_prev;

  function automatic int budget(int i);
    return (i == 0) ? 1800 : 5;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = IDLE;
      m_lives[i] = 3;
      m_level[i] = 0;
      m_time[i]  = budget(i);
      m_fc[i]    = 0;
      m_eg[i]    = 0;
      m_pend[i]  = 0;
    end
    m_prev = 1;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int   edge_seen;
    state_e nxt;
    int   eg;
    if (reset) begin
      model_reset();
      return;
    end
    edge_seen = (m_prev == 1 && startKeyN == 1'b0) ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      nxt = m_state[i];
      eg  = 0;
      case (m_state[i])
        IDLE: if (edge_seen == 1 || m_pend[i] == 1) begin
          if (startOfFrame) m_pend[i] = 1;
          else begin
            nxt = SPAWN; m_lives[i] = 3; m_level[i] = 0;
            m_time[i] = budget(i); eg = 1; m_pend[i] = 0;
          end
        end
        SPAWN: if (m_fc[i] == 30) nxt = PLAY;
        PLAY: begin
          if (hitHazard) nxt = DYING;
          else if (hitGoal) nxt = WIN_LEVEL;
          else if (startOfFrame) begin
            if (m_time[i] == 1) begin m_time[i] = 0; nxt = DYING; end
            else if (m_time[i] > 0) m_time[i] = m_time[i] - 1;
          end
        end
        DYING: if (m_fc[i] >= 45) begin
          if (m_lives[i] <= 1) begin nxt = GAME_OVER; m_lives[i] = 0; end
          else if (!startOfFrame) begin
            nxt = SPAWN; m_lives[i] = m_lives[i] - 1; m_time[i] = budget(i); eg = 1;
          end
        end
        WIN_LEVEL: if (m_fc[i] >= 60) begin
          if (m_level[i] == 3) nxt = VICTORY;
          else if (!startOfFrame) begin
            nxt = SPAWN; m_level[i] = m_level[i] + 1; m_time[i] = budget(i); eg = 1;
          end
        end
        default: if (edge_seen == 1) nxt = IDLE;
      endcase
      if (nxt != m_state[i]) m_fc[i] = 0;
      else if (startOfFrame) m_fc[i] = (m_fc[i] + 1) % 256;
      m_state[i] = nxt;
      m_eg[i]    = eg;
    end
    m_prev = int'(startKeyN);
  endtask

  // ---------------- checking ----------------
  task automatic chk(string nm, int i, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d at %0t: got %0d, expected %0d", nm, i, $time, act, exp);
    end
  endtask

  task automatic check_all(int i);
    bit play;
    play = (m_state[i] == PLAY);
    chk("state", i, st_o[i], int'(m_state[i]));
    chk("lives", i, lives_o[i], m_lives[i]);
    chk("level", i, level_o[i], m_level[i]);
    chk("timeLeft", i, time_o[i], m_time[i]);
    chk("EndGame", i, eg_o[i], m_eg[i]);
    chk("rightN", i, rn_o[i], play ? rightN_in : 1'b1);
    chk("leftN", i, ln_o[i], play ? leftN_in : 1'b1);
    chk("jumpN", i, jn_o[i], play ? jumpN_in : 1'b1);
    chk("Y_ACCEL", i, yacc_o[i], 3 + m_level[i]);
    chk("sideSpeedX", i, side_o[i], 76 + 8 * m_level[i]);
    chk("jumpSpeedYstep", i, jstep_o[i], 100);
    chk("jumpSpeedYUp", i, jup_o[i], 200);
    chk("Y_SPEED_LOWER_LIMIT", i, ylo_o[i], 170);
    chk("Y_SPEED_UPPER_LIMIT", i, yhi_o[i], 250);
    chk("gameOver", i, go_o[i], m_state[i] == GAME_OVER);
    chk("victory", i, vic_o[i], m_state[i] == VICTORY);
  endtask

  // One clock: called at posedge+1 with inputs set; keys randomised here.
  task automatic cyc();
    rightN_in = 1'($urandom_range(0, 1));
    leftN_in  = 1'($urandom_range(0, 1));
    jumpN_in  = 1'($urandom_range(0, 1));
    #1;
    check_all(0);
    check_all(1);
    if (eg_o[0]) eg_cnt++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(int n);
    repeat (n) begin
      startOfFrame = 1'b1; cyc();
      startOfFrame = 1'b0; cyc();
      cyc();
    end
  endtask

  typedef struct {
    bit key; bit hz; bit gl; int nfr;
    int st; int lv; int lev; int side; int egs;
  } vec_t;

  vec_t vt [22];

  initial begin
    // key hz gl frames | state lives level sideSpeedX EndGame-pulses (dut0)
    vt[0]  = '{1, 0, 0,  0, 1, 3, 0,  76, 1};
    vt[1]  = '{0, 0, 0, 30, 2, 3, 0,  76, 0};
    vt[2]  = '{0, 1, 1,  0, 3, 3, 0,  76, 0};
    vt[3]  = '{0, 0, 0, 45, 1, 2, 0,  76, 1};
    vt[4]  = '{0, 0, 0, 30, 2, 2, 0,  76, 0};
    vt[5]  = '{0, 0, 1,  0, 4, 2, 0,  76, 0};
    vt[6]  = '{0, 0, 0, 60, 1, 2, 1,  84, 1};
    vt[7]  = '{0, 0, 0, 30, 2, 2, 1,  84, 0};
    vt[8]  = '{0, 1, 0, 45, 1, 1, 1,  84, 1};
    vt[9]  = '{0, 0, 0, 30, 2, 1, 1,  84, 0};
    vt[10] = '{0, 1, 0, 45, 5, 0, 1,  84, 0};
    vt[11] = '{1, 0, 0,  0, 0, 0, 1,  84, 0};
    vt[12] = '{1, 0, 0,  0, 1, 3, 0,  76, 1};
    vt[13] = '{0, 0, 0, 30, 2, 3, 0,  76, 0};
    vt[14] = '{0, 0, 1, 60, 1, 3, 1,  84, 1};
    vt[15] = '{0, 0, 0, 30, 2, 3, 1,  84, 0};
    vt[16] = '{0, 0, 1, 60, 1, 3, 2,  92, 1};
    vt[17] = '{0, 0, 0, 30, 2, 3, 2,  92, 0};
    vt[18] = '{0, 0, 1, 60, 1, 3, 3, 100, 1};
    vt[19] = '{0, 0, 0, 30, 2, 3, 3, 100, 0};
    vt[20] = '{0, 0, 1, 60, 6, 3, 3, 100, 0};
    vt[21] = '{1, 0, 0,  0, 0, 3, 3, 100, 0};

    reset = 1'b1; startOfFrame = 1'b0; startKeyN = 1'b1;
    hitHazard = 1'b0; hitGoal = 1'b0;
    rightN_in = 1'b1; leftN_in = 1'b1; jumpN_in = 1'b1;
    model_reset();
    @(posedge clk); #1;
    cyc();
    reset = 1'b0;
    cyc();

    // Directed scenario table.
    for (int v = 0; v < 22; v++) begin
      eg_cnt = 0;
      startKeyN = !vt[v].key; hitHazard = vt[v].hz; hitGoal = vt[v].gl;
      cyc(); cyc();
      startKeyN = 1'b1; hitHazard = 1'b0; hitGoal = 1'b0;
      cyc();
      frames(vt[v].nfr);
      chk($sformatf("tbl%0d_state", v), 0, st_o[0], vt[v].st);
      chk($sformatf("tbl%0d_lives", v), 0, lives_o[0], vt[v].lv);
      chk($sformatf("tbl%0d_level", v), 0, level_o[0], vt[v].lev);
      chk($sformatf("tbl%0d_sideSpeedX", v), 0, side_o[0], vt[v].side);
      chk($sformatf("tbl%0d_endgame_pulses", v), 0, eg_cnt, vt[v].egs);
    end

    // Level timer expiry on the 5-frame instance, then a deferred respawn.
    reset = 1'b1; model_reset(); cyc();
    reset = 1'b0; cyc();
    startKeyN = 1'b0; cyc();
    startKeyN = 1'b1; cyc();
    frames(30);
    chk("timer_play", 1, st_o[1], int'(PLAY));
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("timer_count%0d", k), 1, time_o[1], 5 - k);
      frames(1);
    end
    chk("timer_dying", 1, st_o[1], int'(DYING));
    chk("timer_zero", 1, time_o[1], 0);
    frames(44);
    startOfFrame = 1'b1; cyc();
    cyc();
    startOfFrame = 1'b0;
    chk("defer_no_pulse", 1, eg_o[1], 0);
    chk("defer_still_dying", 1, st_o[1], int'(DYING));
    cyc();
    chk("defer_pulse", 1, eg_o[1], 1);
    chk("defer_spawn", 1, st_o[1], int'(SPAWN));
    cyc();
    chk("defer_pulse_width", 1, eg_o[1], 0);

    // Asynchronous reset in the middle of WIN_LEVEL on the default instance.
    hitHazard = 1'b1; cyc(); hitHazard = 1'b0;
    frames(45); frames(30);
    hitGoal = 1'b1; cyc(); hitGoal = 1'b0;
    frames(60); frames(30);
    hitGoal = 1'b1; cyc(); hitGoal = 1'b0;
    frames(10);
    chk("midwin_state", 0, st_o[0], int'(WIN_LEVEL));
    chk("midwin_level", 0, level_o[0], 1);
    chk("midwin_lives", 0, lives_o[0], 2);
    reset = 1'b1; model_reset();
    #1;
    chk("async_state", 0, st_o[0], int'(IDLE));
    chk("async_lives", 0, lives_o[0], 3);
    chk("async_level", 0, level_o[0], 0);
    chk("async_side", 0, side_o[0], 76);
    cyc();
    reset = 1'b0;
    cyc();

    // Randomised play against the models.
    for (int n = 0; n < 4000; n++) begin
      startOfFrame = ($urandom_range(0, 2) == 0);
      hitHazard    = ($urandom_range(0, 99) == 0);
      hitGoal      = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) startKeyN = ~startKeyN;
      if ($urandom_range(0, 2999) == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        reset = 1'b0;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bumpy_game_ctrl.md
Name: bumpy_game_ctrl

Overview:
- Game-level sequencer for the Bumpy player-movement datapath; one instance in the VGA game top.
- Decides when the player may move, and when the player is respawned (EndGame pulse).
- Owns lives, level and the per-level countdown timer.
- Drives the per-level physics configuration consumed by the movement block (Y_ACCEL, sideSpeedX, jump speeds, Y speed limits).
- Gates the raw active-low keys so movement only happens in PLAY.

Parameters:
- START_LIVES, 3, lives loaded at game start (1..7).
- NUM_LEVELS, 4, levels before VICTORY (1..4; physics table has 4 entries).
- SPAWN_FRAMES, 30, frozen frames after respawn before PLAY.
- DEATH_FRAMES, 45, frozen frames of death animation.
- WIN_FRAMES, 60, frozen frames of level-complete banner.
- LEVEL_TIME_FRAMES, 1800, per-level time budget in frames (60 s at 30 Hz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- startKeyN  in  1  raw start key, active-low; level-sensitive, edge-detected inside.
- rightN_in / leftN_in / jumpN_in  in  1 each  raw keys, active-low.
- hitHazard  in  1  player collided with hazard or left the screen.
- hitGoal  in  1  player collided with goal tile.
- rightN / leftN / jumpN  out  1 each  gated keys to the movement block.
- EndGame  out  1  one-cycle respawn pulse to the movement block.
- Y_ACCEL, sideSpeedX, jumpSpeedYstep, jumpSpeedYUp, Y_SPEED_LOWER_LIMIT, Y_SPEED_UPPER_LIMIT  out  32 each  physics for current level.
- lives  out  3  remaining lives.
- level  out  2  current level, 0-based.
- timeLeft  out  11  frames remaining / 1 (raw counter, display divides).
- state_o  out  3  encoded state, for HUD/debug.
- gameOver / victory  out  1 each  high while in the matching state.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - state=IDLE; lives=START_LIVES; level=0; timeLeft=LEVEL_TIME_FRAMES; frame counter=0; EndGame=0.
  - Gated keys all 1; physics outputs = level-0 table entry.
  - Start-key edge detector register = 1, so no false edge out of reset.
- Start edge = startKeyN falling (registered previous 1, current 0).
- Key gating:
  - In PLAY: rightN/leftN/jumpN = inputs, combinational pass-through.
  - In every other state: all three forced to 1.
- Physics outputs: combinational lookup of the package table indexed by level; they change the cycle after level updates.
- Frame counter (fc): 8 bits; cleared on every state entry; increments on startOfFrame only.
- States and transitions (registered, one per clock):
  - IDLE: start edge -> SPAWN, with lives=START_LIVES, level=0, timeLeft reloaded, EndGame=1 for that cycle.
  - SPAWN: fc==SPAWN_FRAMES -> PLAY.
  - PLAY:
    - hitHazard -> DYING; hazard has priority when hitHazard and hitGoal are high in the same cycle.
    - else hitGoal -> WIN_LEVEL.
    - else startOfFrame with timeLeft==1 -> DYING, timeLeft becomes 0.
    - else on startOfFrame timeLeft decrements by 1; it never wraps below 0.
  - DYING: fc==DEATH_FRAMES:
    - lives==1 -> GAME_OVER, lives=0.
    - else lives-1, timeLeft reloaded, EndGame pulse, -> SPAWN.
  - WIN_LEVEL: fc==WIN_FRAMES:
    - level==NUM_LEVELS-1 -> VICTORY.
    - else level+1, timeLeft reloaded, EndGame pulse, -> SPAWN.
  - GAME_OVER / VICTORY: start edge -> IDLE; no auto-restart.
- hitHazard and hitGoal are ignored outside PLAY, since the respawn may overlap a collision.
- EndGame:
  - Exactly one clock wide, registered, coincident with the SPAWN entry edge.
  - Never asserted on the same cycle as startOfFrame. If a transition into SPAWN would coincide with startOfFrame, it is deferred one cycle, so the movement block's position reload is not overridden by its frame integral.
- Counter and width rules:
  - All counters are unsigned.
  - lives saturates at 0.
  - Physics table values are signed 32-bit.

Decomposition:
- Package bumpy_game_pkg holds:
  - state enum: IDLE, SPAWN, PLAY, DYING, WIN_LEVEL, GAME_OVER, VICTORY (3 bits).
  - struct physics_t with the six 32-bit fields.
  - constant PHYS_TABLE[4] of physics_t. Level 0 = {3, 76, 100, 200, 170, 250}; later levels increase sideSpeedX by 8 and Y_ACCEL by 1 per level.
- One sub-module: bumpy_edge_detect, a registered falling-edge detector used for startKeyN.

Test Plan:
- Reset, then start key pressed 2 cycles -> one EndGame pulse; state SPAWN; lives=3, level=0; gated keys held 1; after 30 startOfFrame pulses -> PLAY and keys pass through.
- PLAY, hitHazard and hitGoal asserted on the same cycle -> DYING, not WIN_LEVEL; after 45 frames lives=2, EndGame pulses, then SPAWN.
- Three hazards in sequence -> third DYING ends in GAME_OVER with lives=0 and no EndGame; start edge -> IDLE.
- hitGoal on level 3 (NUM_LEVELS=4) -> WIN_LEVEL, then VICTORY after 60 frames, level stays 3; on levels 0-2 level increments and sideSpeedX steps 76 -> 84.
- LEVEL_TIME_FRAMES=5 override: no collisions for 5 frames -> timeLeft 5..1, then DYING with timeLeft=0.
- DYING completes on a cycle coincident with startOfFrame -> EndGame appears exactly one cycle later; reset asserted mid-WIN_LEVEL -> immediate IDLE, lives=3, level=0.
